// File: rtl/dmac_pkg.sv
// Shared constants and types for the DMA controller register slice.
package dmac_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 8;

  // Register byte offsets
  localparam logic [ADDR_W-1:0] SADDR_OFF  = 8'h00;
  localparam logic [ADDR_W-1:0] DADDR_OFF  = 8'h04;
  localparam logic [ADDR_W-1:0] CTRL_OFF   = 8'h08;
  localparam logic [ADDR_W-1:0] BLK_OFF    = 8'h0C;
  localparam logic [ADDR_W-1:0] CMD_OFF    = 8'h10;
  localparam logic [ADDR_W-1:0] STATUS_OFF = 8'h14;
  localparam logic [ADDR_W-1:0] IE_OFF     = 8'h18;
  localparam logic [ADDR_W-1:0] PIRQ_OFF   = 8'h1C;

  // CTRL field layout
  localparam int unsigned CTRL_FIELD_W    = 3;
  localparam int unsigned CTRL_SSIZE_LSB  = 0;
  localparam int unsigned CTRL_DSIZE_LSB  = 4;
  localparam int unsigned CTRL_SINC_LSB   = 8;
  localparam int unsigned CTRL_DINC_LSB   = 12;
  localparam int unsigned CTRL_WFI_BIT    = 16;
  localparam int unsigned CTRL_IRQSRC_LSB = 20;

  // BLK field layout
  localparam int unsigned BLK_FIELD_W    = 8;
  localparam int unsigned BLK_BSIZE_LSB  = 0;
  localparam int unsigned BLK_BCOUNT_LSB = 8;

  // Single-bit fields of CMD / STATUS / IE
  localparam int unsigned CMD_GO_BIT      = 0;
  localparam int unsigned STATUS_BUSY_BIT = 0;
  localparam int unsigned STATUS_DONE_BIT = 1;
  localparam int unsigned IE_EN_BIT       = 0;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef struct packed {
    logic [CTRL_FIELD_W-1:0] irqsrc;
    logic                    wfi;
    logic [CTRL_FIELD_W-1:0] dinc;
    logic [CTRL_FIELD_W-1:0] sinc;
    logic [CTRL_FIELD_W-1:0] dsize;
    logic [CTRL_FIELD_W-1:0] ssize;
  } ctrl_t;

  // Extract CTRL fields from a bus word
  function automatic ctrl_t ctrl_unpack(input logic [DATA_W-1:0] w);
    ctrl_t c;
    c.ssize  = w[CTRL_SSIZE_LSB  +: CTRL_FIELD_W];
    c.dsize  = w[CTRL_DSIZE_LSB  +: CTRL_FIELD_W];
    c.sinc   = w[CTRL_SINC_LSB   +: CTRL_FIELD_W];
    c.dinc   = w[CTRL_DINC_LSB   +: CTRL_FIELD_W];
    c.wfi    = w[CTRL_WFI_BIT];
    c.irqsrc = w[CTRL_IRQSRC_LSB +: CTRL_FIELD_W];
    return c;
  endfunction

  // Place CTRL fields back into a bus word; unused bits stay 0
  function automatic logic [DATA_W-1:0] ctrl_pack(input ctrl_t c);
    logic [DATA_W-1:0] w;
    w = '0;
    w[CTRL_SSIZE_LSB  +: CTRL_FIELD_W] = c.ssize;
    w[CTRL_DSIZE_LSB  +: CTRL_FIELD_W] = c.dsize;
    w[CTRL_SINC_LSB   +: CTRL_FIELD_W] = c.sinc;
    w[CTRL_DINC_LSB   +: CTRL_FIELD_W] = c.dinc;
    w[CTRL_WFI_BIT]                    = c.wfi;
    w[CTRL_IRQSRC_LSB +: CTRL_FIELD_W] = c.irqsrc;
    return w;
  endfunction

endpackage

// File: rtl/dmac_sync.sv
// Per-bit flop-chain synchroniser with configurable depth.
module dmac_sync #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [STAGES-1:0][WIDTH-1:0] r_chain;

  // Shift the asynchronous inputs through the chain; stage 0 is the capture flop
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_chain[STAGES-1];

endmodule

// File: rtl/dmac_ahbl_regs.sv
// AHB-Lite register file holding DMA channel configuration, start/done/irq
// handling and the peripheral-request synchroniser feeding the master.
module dmac_ahbl_regs
  import dmac_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NPIRQ       = 8
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic              HREADY,
  input  logic [DATA_W-1:0] HWDATA,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  input  logic [NPIRQ-1:0]  pirq_in,
  output logic [DATA_W-1:0] saddr,
  output logic [DATA_W-1:0] daddr,
  output logic [2:0]        ssize,
  output logic [2:0]        dsize,
  output logic [2:0]        sinc,
  output logic [2:0]        dinc,
  output logic [2:0]        irqsrc,
  output logic [7:0]        bsize,
  output logic [7:0]        bcount,
  output logic              wfi,
  output logic              start,
  output logic [NPIRQ-1:0]  pirq,
  input  logic              done,
  input  logic              busy,
  output logic              irq
);

  // Latched address phase
  logic              r_valid;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;

  // Architectural registers
  logic [DATA_W-1:0] r_saddr;
  logic [DATA_W-1:0] r_daddr;
  ctrl_t             r_ctrl;
  logic [7:0]        r_bsize;
  logic [7:0]        r_bcount;
  logic              r_start;
  logic              r_done;
  logic              r_ie;
  logic              r_irq;

  // Data-phase decode
  logic              w_wr;
  logic              w_cfg_we;
  logic              w_start_next;
  logic              w_done_next;
  logic              w_ie_next;
  logic [DATA_W-1:0] w_rdata;

  // Size, byte lane and the BUSY/SEQ distinction carry no meaning here
  logic w_unused;
  assign w_unused = &{1'b0, HSIZE, HADDR[1:0], HTRANS[0]};

  // Capture the address phase; an active transfer needs select plus NONSEQ/SEQ
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_valid <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= '0;
    end else if (HREADY) begin
      r_valid <= HSEL & HTRANS[1];
      r_write <= HWRITE;
      r_addr  <= {HADDR[ADDR_W-1:2], 2'b00};
    end
  end

  // Write decode, start/done/ie next values and the read mux
  always_comb begin
    w_wr         = r_valid & r_write & HREADY;
    w_cfg_we     = w_wr & ~busy;
    w_start_next = 1'b0;
    w_ie_next    = r_ie;
    w_done_next  = r_done;
    w_rdata      = '0;

    if (w_wr && (r_addr == CMD_OFF)) begin
      w_start_next = HWDATA[CMD_GO_BIT] & ~busy;
    end
    if (w_wr && (r_addr == IE_OFF)) begin
      w_ie_next = HWDATA[IE_EN_BIT];
    end
    if (w_wr && (r_addr == STATUS_OFF) && HWDATA[STATUS_DONE_BIT]) begin
      w_done_next = 1'b0;
    end
    // A completion in the same cycle as the clear must not be lost
    if (done) begin
      w_done_next = 1'b1;
    end

    if (r_valid && !r_write) begin
      case (r_addr)
        SADDR_OFF:  w_rdata = r_saddr;
        DADDR_OFF:  w_rdata = r_daddr;
        CTRL_OFF:   w_rdata = ctrl_pack(r_ctrl);
        BLK_OFF: begin
          w_rdata[BLK_BSIZE_LSB  +: BLK_FIELD_W] = r_bsize;
          w_rdata[BLK_BCOUNT_LSB +: BLK_FIELD_W] = r_bcount;
        end
        STATUS_OFF: begin
          w_rdata[STATUS_BUSY_BIT] = busy;
          w_rdata[STATUS_DONE_BIT] = r_done;
        end
        IE_OFF:     w_rdata[IE_EN_BIT] = r_ie;
        PIRQ_OFF:   w_rdata = DATA_W'(pirq);
        default:    w_rdata = '0;
      endcase
    end
  end

  // Register updates; configuration is frozen while the master is busy
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_saddr  <= '0;
      r_daddr  <= '0;
      r_ctrl   <= '0;
      r_bsize  <= '0;
      r_bcount <= '0;
      r_start  <= 1'b0;
      r_done   <= 1'b0;
      r_ie     <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_cfg_we && (r_addr == SADDR_OFF)) r_saddr <= HWDATA;
      if (w_cfg_we && (r_addr == DADDR_OFF)) r_daddr <= HWDATA;
      if (w_cfg_we && (r_addr == CTRL_OFF))  r_ctrl  <= ctrl_unpack(HWDATA);
      if (w_cfg_we && (r_addr == BLK_OFF)) begin
        r_bsize  <= HWDATA[BLK_BSIZE_LSB  +: BLK_FIELD_W];
        r_bcount <= HWDATA[BLK_BCOUNT_LSB +: BLK_FIELD_W];
      end
      r_start <= w_start_next;
      r_done  <= w_done_next;
      r_ie    <= w_ie_next;
      r_irq   <= w_done_next & w_ie_next;
    end
  end

  // Peripheral request synchroniser
  dmac_sync #(
    .WIDTH  (NPIRQ),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (HCLK),
    .i_rst   (HRESET),
    .i_async (pirq_in),
    .o_sync  (pirq)
  );

  assign HRDATA    = w_rdata;
  assign HREADYOUT = 1'b1;
  assign saddr     = r_saddr;
  assign daddr     = r_daddr;
  assign ssize     = r_ctrl.ssize;
  assign dsize     = r_ctrl.dsize;
  assign sinc      = r_ctrl.sinc;
  assign dinc      = r_ctrl.dinc;
  assign wfi       = r_ctrl.wfi;
  assign irqsrc    = r_ctrl.irqsrc;
  assign bsize     = r_bsize;
  assign bcount    = r_bcount;
  assign start     = r_start;
  assign irq       = r_irq;

endmodule

// File: tb/tb_dmac_ahbl_regs.sv
// Bench for dmac_ahbl_regs: directed bus traffic, a register-map model
// checked every cycle, plus hand-computed literal expectations.
module tb_dmac_ahbl_regs;

  localparam int unsigned S    = 2;
  localparam int          LOGN = 2048;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        HSEL = 1'b0;
  logic [7:0]  HADDR = '0;
  logic [1:0]  HTRANS = 2'b00;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'b010;
  logic        HREADY = 1'b1;
  logic [31:0] HWDATA = '0;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic [7:0]  pirq_in = '0;
  logic [31:0] saddr, daddr;
  logic [2:0]  ssize, dsize, sinc, dinc, irqsrc;
  logic [7:0]  bsize, bcount;
  logic        wfi, start, irq;
  logic [7:0]  pirq;
  logic        done = 1'b0;
  logic        busy = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 HCLK = ~HCLK;

  dmac_ahbl_regs #(.SYNC_STAGES(S), .NPIRQ(8)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .pirq_in(pirq_in),
    .saddr(saddr), .daddr(daddr), .ssize(ssize), .dsize(dsize), .sinc(sinc),
    .dinc(dinc), .irqsrc(irqsrc), .bsize(bsize), .bcount(bcount), .wfi(wfi),
    .start(start), .pirq(pirq), .done(done), .busy(busy), .irq(irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_cfg [4];   // SADDR, DADDR, CTRL, BLK as they read back
  logic        m_done, m_ie, m_start, m_irq;
  logic        p_valid, p_write;
  logic [7:0]  p_addr;
  logic [7:0]  pin_log [LOGN];
  int          cyc = 0;
  int          last_rst = 0;
  bit          m_live = 1'b0;
  logic        d_n, i_n, s_n;

  function automatic logic [31:0] cfg_mask(input logic [1:0] idx);
    case (idx)
      2'd2:    return 32'h0071_7777;
      2'd3:    return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // pirq after edge 'cyc' is the input sampled S-1 edges earlier, zero if a reset intervened
  function automatic logic [7:0] exp_pirq();
    int k;
    k = cyc - int'(S) + 1;
    if (k > last_rst) return pin_log[k % LOGN];
    return 8'h00;
  endfunction

  function automatic logic [31:0] exp_rdata();
    case (p_addr)
      8'h00, 8'h04, 8'h08, 8'h0C: return m_cfg[p_addr[3:2]];
      8'h14:   return {30'b0, m_done, busy};
      8'h18:   return {31'b0, m_ie};
      8'h1C:   return {24'b0, exp_pirq()};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge HCLK) begin
    cyc = cyc + 1;
    pin_log[cyc % LOGN] = pirq_in;
    if (HRESET) begin
      for (int i = 0; i < 4; i++) m_cfg[i] = '0;
      m_done = 0; m_ie = 0; m_start = 0; m_irq = 0;
      p_valid = 0; p_write = 0; p_addr = '0;
      last_rst = cyc;
      m_live = 1'b1;
    end else begin
      d_n = m_done; i_n = m_ie; s_n = 1'b0;
      if (p_valid && p_write && HREADY) begin
        case (p_addr)
          8'h00, 8'h04, 8'h08, 8'h0C:
            if (!busy) m_cfg[p_addr[3:2]] = HWDATA & cfg_mask(p_addr[3:2]);
          8'h10: s_n = HWDATA[0] & ~busy;
          8'h14: if (HWDATA[1]) d_n = 1'b0;
          8'h18: i_n = HWDATA[0];
          default: ;
        endcase
      end
      if (done) d_n = 1'b1;
      m_done = d_n; m_ie = i_n; m_start = s_n; m_irq = d_n & i_n;
      if (HREADY) begin
        p_valid = HSEL & HTRANS[1];
        p_write = HWRITE;
        p_addr  = {HADDR[7:2], 2'b00};
      end
    end
  end

  // Compare every cycle once reset has been seen
  always @(negedge HCLK) begin
    if (m_live) begin
      chk("hreadyout", 32'(HREADYOUT), 32'h1);
      chk("saddr", saddr, m_cfg[0]);
      chk("daddr", daddr, m_cfg[1]);
      chk("ctrl_out", {9'b0, irqsrc, 3'b0, wfi, 1'b0, dinc, 1'b0, sinc, 1'b0, dsize, 1'b0, ssize},
          m_cfg[2]);
      chk("blk_out", {16'b0, bcount, bsize}, m_cfg[3]);
      chk("start", 32'(start), 32'(m_start));
      chk("irq", 32'(irq), 32'(m_irq));
      chk("pirq", 32'(pirq), 32'(exp_pirq()));
      if (p_valid && !p_write) chk("hrdata", HRDATA, exp_rdata());
    end
  end

  // ---------------- bus tasks (called at posedge+1) ----------------
  task automatic idle();
    HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HADDR = '0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = a;
    @(posedge HCLK); #1;
    idle(); HWDATA = d;
    @(posedge HCLK); #1;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = a;
    @(posedge HCLK); #1;
    idle();
    @(negedge HCLK); d = HRDATA;
    @(posedge HCLK); #1;
  endtask

  task automatic wr_rd(input logic [7:0] a, input logic [31:0] d, output logic [31:0] q);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = a;
    @(posedge HCLK); #1;
    HWRITE = 0; HWDATA = d;
    @(posedge HCLK); #1;
    idle();
    @(negedge HCLK); q = HRDATA;
    @(posedge HCLK); #1;
  endtask

  task automatic pulse_done();
    done = 1;
    @(posedge HCLK); #1;
    done = 0;
  endtask

  task automatic at_neg();
    @(negedge HCLK);
  endtask

  task automatic to_pos();
    @(posedge HCLK); #1;
  endtask

  logic [31:0] q;

  initial begin
    repeat (3) @(posedge HCLK);
    #1 HRESET = 0;

    // reset state
    at_neg();
    chk("rst_saddr", saddr, 32'h0);
    chk("rst_start", 32'(start), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    to_pos();

    // configuration write / read back
    wr(8'h00, 32'h2000_0000);
    at_neg(); chk("lit_saddr", saddr, 32'h2000_0000); to_pos();
    wr(8'h04, 32'h4000_0010);
    wr(8'h08, 32'h0011_1122);
    at_neg(); chk("lit_dsize", 32'(dsize), 32'h2); chk("lit_sinc", 32'(sinc), 32'h1); to_pos();
    wr(8'h0C, 32'h0000_0403);
    at_neg(); chk("lit_bcount", 32'(bcount), 32'h4); to_pos();
    rd(8'h00, q); chk("rd_saddr", q, 32'h2000_0000);
    rd(8'h04, q); chk("rd_daddr", q, 32'h4000_0010);
    rd(8'h08, q); chk("rd_ctrl", q, 32'h0011_1122);
    rd(8'h0C, q); chk("rd_blk", q, 32'h0000_0403);
    rd(8'h10, q); chk("rd_cmd", q, 32'h0);

    // start handshake
    wr(8'h10, 32'h1);
    at_neg(); chk("start_hi", 32'(start), 32'h1);
    at_neg(); chk("start_lo", 32'(start), 32'h0);
    to_pos();
    busy = 1;
    wr(8'h10, 32'h1);
    at_neg(); chk("start_busy0", 32'(start), 32'h0);
    at_neg(); chk("start_busy1", 32'(start), 32'h0);
    to_pos();
    wr(8'h08, 32'hFFFF_FFFF);
    rd(8'h08, q); chk("ctrl_locked", q, 32'h0011_1122);
    rd(8'h14, q); chk("status_busy", q, 32'h1);
    busy = 0;

    // done / irq
    wr_rd(8'h18, 32'h1, q); chk("ie_b2b", q, 32'h1);
    pulse_done();
    at_neg(); chk("irq_set", 32'(irq), 32'h1); to_pos();
    rd(8'h14, q); chk("status_done", q, 32'h2);
    wr(8'h14, 32'h2);
    at_neg(); chk("irq_clr", 32'(irq), 32'h0); to_pos();
    pulse_done();
    HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = 8'h14;
    to_pos();
    idle(); HWDATA = 32'h2; done = 1;
    to_pos();
    done = 0;
    rd(8'h14, q); chk("set_wins", q, 32'h2);
    chk("set_wins_irq", 32'(irq), 32'h1);
    wr(8'h14, 32'h2);

    // IE masking
    wr(8'h18, 32'h0);
    pulse_done();
    at_neg(); chk("irq_masked", 32'(irq), 32'h0); to_pos();
    wr(8'h18, 32'h1);
    at_neg(); chk("irq_unmask", 32'(irq), 32'h1); to_pos();

    // synchroniser latency
    pirq_in = 8'h80;
    for (int k = 0; k <= int'(S); k++) begin
      at_neg();
      chk("pirq_lat", 32'(pirq), (k == int'(S)) ? 32'h80 : 32'h0);
    end
    to_pos();
    rd(8'h1C, q); chk("rd_pirq", q, 32'h80);
    pirq_in = 8'h5A;
    repeat (4) to_pos();
    rd(8'h1C, q); chk("rd_pirq2", q, 32'h5A);

    // reset in the middle of a write data phase
    HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = 8'h00;
    to_pos();
    idle(); HWDATA = 32'hFFFF_FFFF; HRESET = 1;
    to_pos();
    HRESET = 0;
    at_neg();
    chk("rst2_start", 32'(start), 32'h0);
    chk("rst2_irq", 32'(irq), 32'h0);
    to_pos();
    rd(8'h00, q); chk("rst2_saddr", q, 32'h0);
    rd(8'h3C, q); chk("unmapped", q, 32'h0);
    rd(8'h18, q); chk("rst2_ie", q, 32'h0);
    repeat (3) to_pos();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmac_ahbl_regs.md
Name: dmac_ahbl_regs

Overview:
AHB-Lite slave register file directly upstream of dmac_master. It holds the channel configuration (source/destination address, sizes, increments, block size/count, WFI/IRQ source) and drives those fields straight into the master. It issues the one-cycle start pulse, turns the master's done pulse into a sticky status bit plus an interrupt, and synchronises the external peripheral request lines before they reach the master's pirq input.

Parameters:
SYNC_STAGES, 2, number of flops in the peripheral-request synchroniser (allowed range 2..3)
NPIRQ, 8, number of peripheral request lines (fixed at 8 to match the master's pirq width)

Ports:
HCLK  in  1  bus clock; the only clock
HRESET  in  1  reset; synchronous, active-high
HSEL  in  1  slave select
HADDR  in  8  byte address (bits [4:2] decode the register)
HTRANS  in  2  transfer type; NONSEQ/SEQ = HTRANS[1]
HWRITE  in  1  write when high
HSIZE  in  3  ignored; every access is treated as a 32-bit word
HREADY  in  1  bus ready (qualifies the address phase)
HWDATA  in  32  write data (data phase)
HRDATA  out  32  read data (data phase)
HREADYOUT  out  1  tied high (zero wait states)
pirq_in  in  NPIRQ  asynchronous peripheral requests
saddr, daddr  out  32  to master
ssize, dsize, sinc, dinc, irqsrc  out  3 each  to master
bsize, bcount  out  8 each  to master
wfi  out  1  to master
start  out  1  one-cycle start pulse to master
pirq  out  NPIRQ  synchronised requests to master
done  in  1  one-cycle completion pulse from master
busy  in  1  master busy level
irq  out  1  interrupt = DONE sticky AND IE

Behaviour:
- Register map (word offsets):
  - 0x00 SADDR, RW.
  - 0x04 DADDR, RW.
  - 0x08 CTRL, RW: ssize[2:0], dsize[6:4], sinc[10:8], dinc[14:12], wfi[16], irqsrc[22:20].
  - 0x0C BLK, RW: bsize[7:0], bcount[15:8].
  - 0x10 CMD, WO: bit0 = go. Reads as 0.
  - 0x14 STATUS: busy[0] RO, done[1] W1C.
  - 0x18 IE, RW: bit0.
  - 0x1C PIRQ, RO: synchronised pirq[7:0].
  - Unmapped offsets read 0; writes to them are ignored.
  - Unused bits read 0.
- Address phase: capture addr/write/valid when HSEL & HTRANS[1] & HREADY.
- Data phase:
  - A write commits at the HCLK edge that ends the data phase, using HWDATA.
  - A read drives HRDATA combinationally from the latched address.
  - Back-to-back write-then-read of the same register returns the new value.
- HREADYOUT is always 1, so there are no wait states.
- Config lock: while busy=1, writes to SADDR/DADDR/CTRL/BLK are ignored, so outputs stay stable for the whole transfer.
- start:
  - Asserted for exactly one cycle, the cycle after a CMD write with bit0=1 commits, only if busy=0 at commit.
  - A CMD write while busy is dropped (no queued start).
- DONE sticky:
  - Set on done=1.
  - Cleared by a STATUS write with bit1=1.
  - If set and clear happen in the same cycle, set wins.
- irq is registered: irq <= DONE_next & IE_next, so it follows any change one cycle later.
- pirq: SYNC_STAGES-deep flop chain per bit. Latency from pirq_in to pirq is SYNC_STAGES cycles. No edge detection.
- Reset (HRESET=1 at an edge): every register, DONE, IE, start, irq and the sync flops go to 0. An in-flight bus transfer is discarded and HRDATA reads 0 afterwards. Reset mid-transfer does not reset the master; the master has its own reset.
- All outputs to the master are direct register outputs; no combinational paths from the AHB inputs.

Decomposition:
- dmac_pkg holds:
  - register offset constants (SADDR_OFF … PIRQ_OFF);
  - CTRL/STATUS field bit positions and widths;
  - the HTRANS encodings.
- One sub-module, dmac_sync: a parameterised-depth, per-bit synchroniser, instantiated once with width NPIRQ.

Test Plan:
- Config write/read: write SADDR=0x2000_0000, DADDR=0x4000_0010, CTRL=0x0011_1122, BLK=0x0403; read back -> identical values; saddr/dsize/sinc/bcount outputs match field values one cycle after each write.
- Start handshake: with busy=0, write CMD=1 -> start high exactly one cycle. Hold busy=1 and write CMD=1 again -> no start pulse. A CTRL write during busy leaves CTRL unchanged.
- Done/IRQ: IE=1, pulse done -> STATUS reads 0x2 (busy=0), irq=1 next cycle. Write STATUS=0x2 -> irq=0. Pulse done in the same cycle as the W1C -> DONE stays 1.
- IE masking: IE=0, pulse done -> irq stays 0. Later write IE=1 -> irq=1 one cycle after the commit.
- Sync: drive pirq_in=0x80 -> pirq=0x80 exactly SYNC_STAGES cycles later. PIRQ register read returns 0x80.
- Reset: assert HRESET mid-way through a write data phase to SADDR=0xFFFF_FFFF -> SADDR reads 0, start=0, irq=0, and the unmapped offset 0x3C reads 0.
